hazard_unit: RTL and testbench

Central pipeline controller for the 5-stage RISC-V core. It generates the stall and flush enables for the fetch-to-decode, decode-to-execute, execute-to-memory and memory-to-writeback pipeline registers, and the execute-stage forwarding selects. It also sequences a post-reset pipeline scrub and multi-cycle data-memory waits, with timeout detection and saturating performance counters.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_unit_sat_counter.sv | 27 ++
 rtl/hazard_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and forwarding encodings for the 5-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The memory stage holds the younger result, so it wins over writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != MAX))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/forward generation, reset scrub,
// data-memory wait sequencing with timeout, and saturating performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic              w_in_init;
    logic              w_mem_stall;
    logic              w_lw_stall;
    logic              w_branch_flush;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic              r_timeout;

    assign w_in_init   = (r_state == INIT);
    assign w_mem_stall = MemReqM && !MemReadyM;
    assign w_lw_stall  = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (w_in_init) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (w_mem_stall) begin
            // A taken branch in execute is simply held there until the access completes.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign w_branch_flush = !w_in_init && !w_mem_stall && PCSrcE;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:     w_state_nxt = RUN;
            RUN:      if (w_mem_stall) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (MemReadyM) w_state_nxt = RUN;
            default:  w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= INIT;
        else
            r_state <= w_state_nxt;
    end

    sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (WAIT_W'(MEM_TIMEOUT))
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_state == MEM_WAIT),
        .clr   ((r_state == RUN) && w_mem_stall),
        .count (w_wait_cnt)
    );

    // Raised on the same edge the wait counter reaches the limit; sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timeout <= 1'b0;
        else if ((r_state == MEM_WAIT) && (w_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)))
            r_timeout <= 1'b1;
    end

    assign MemTimeout = r_timeout;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF && !w_in_init),
        .clr   (1'b0),
        .count (StallCycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch_flush),
        .clr   (1'b0),
        .count (FlushEvents)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed plan steps, then randomized traffic
// compared cycle by cycle against a behavioural reference model.
module tb_hazard_unit;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, MemReadE, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCycles, FlushEvents;

    hazard_unit #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemReadE    (MemReadE),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MemTimeout  (MemTimeout),
        .StallCycles (StallCycles),
        .FlushEvents (FlushEvents)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: "scrubbing" and "waiting" flags plus plain integer counts.
    bit          m_scrub;
    bit          m_waiting;
    int          m_wait_cycles;
    bit          m_timeout;
    longint      m_stalls;
    longint      m_flushes;
    longint      cnt_max = (64'd1 << CNT_W) - 1;

    logic [3:0]  e_stall;   // {F,D,E,M}
    logic [3:0]  e_flush;   // {D,E,M,W}
    logic [1:0]  e_fa, e_fb;
    bit          e_branch;
    bit          e_mem;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic predict();
        bit lw;
        e_mem    = MemReqM && !MemReadyM;
        lw       = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        e_fa     = ref_fwd(Rs1E);
        e_fb     = ref_fwd(Rs2E);
        e_stall  = 4'b0000;
        e_flush  = 4'b0000;
        e_branch = 1'b0;
        if (m_scrub) begin
            e_stall = 4'b1000;
            e_flush = 4'b1111;
        end else if (e_mem) begin
            e_stall = 4'b1111;
            e_flush = 4'b0001;
        end else if (PCSrcE) begin
            e_flush  = 4'b1100;
            e_branch = 1'b1;
        end else if (lw) begin
            e_stall = 4'b1100;
            e_flush = 4'b0100;
        end
    endtask

    task automatic check_comb(input string tag);
        predict();
        check({tag, "_stall"}, {28'd0, StallF, StallD, StallE, StallM}, {28'd0, e_stall});
        check({tag, "_flush"}, {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, e_flush});
        check({tag, "_fwdA"}, {30'd0, ForwardAE}, {30'd0, e_fa});
        check({tag, "_fwdB"}, {30'd0, ForwardBE}, {30'd0, e_fb});
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_stallcnt"}, StallCycles, m_stalls[31:0]);
        check({tag, "_flushcnt"}, FlushEvents, m_flushes[31:0]);
        check({tag, "_timeout"}, {31'd0, MemTimeout}, {31'd0, m_timeout});
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input string tag);
        #3;
        check_comb(tag);
        @(posedge clk);
        if (m_scrub) begin
            m_scrub = 1'b0;
        end else begin
            if (e_stall[3] && m_stalls < cnt_max) m_stalls++;
            if (e_branch && m_flushes < cnt_max) m_flushes++;
            if (m_waiting) begin
                m_wait_cycles++;
                if (m_wait_cycles >= MEM_TIMEOUT) m_timeout = 1'b1;
                if (MemReadyM) m_waiting = 1'b0;
            end else if (e_mem) begin
                m_waiting     = 1'b1;
                m_wait_cycles = 0;
            end
        end
        #1;
        check_regs(tag);
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, MemReadE, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic do_reset(input string tag);
        rst_n         = 1'b0;
        m_scrub       = 1'b1;
        m_waiting     = 1'b0;
        m_wait_cycles = 0;
        m_timeout     = 1'b0;
        m_stalls      = 0;
        m_flushes     = 0;
        #2;
        check_comb({tag, "_inrst"});
        check_regs({tag, "_inrst"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle({tag, "_scrub"});
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;

        // Reset scrub, then quiet pipeline.
        do_reset("rst");
        cycle("idle");
        check("idle_nostall", {31'd0, StallF}, 32'd0);

        // Forwarding priority.
        Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #3;
        check("fwd_mem", {30'd0, ForwardAE}, 32'd2);
        #1;
        @(posedge clk); #1;
        RegWriteM = 1'b0;
        #3;
        check("fwd_wb", {30'd0, ForwardAE}, 32'd1);
        #1;
        @(posedge clk); #1;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        #3;
        check("fwd_x0", {30'd0, ForwardAE}, 32'd0);
        #1;
        @(posedge clk); #1;
        cycle("fwd_model");

        // Load-use stall.
        idle_inputs();
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        cycle("lw");
        check("lw_stallcnt", StallCycles, 32'd1);
        idle_inputs();
        cycle("lw_after");

        // Branch beats load-use.
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        cycle("br_lw");
        check("br_flushcnt", FlushEvents, 32'd1);
        idle_inputs();

        // Memory wait of three cycles.
        do_reset("mw_rst");
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) cycle("mw_wait");
        MemReadyM = 1'b1;
        cycle("mw_ready");
        check("mw_stallcnt", StallCycles, 32'd3);
        idle_inputs();
        cycle("mw_back");

        // Reset in the middle of a wait abandons it.
        MemReqM = 1'b1;
        cycle("abort_a");
        cycle("abort_b");
        do_reset("abort_rst");
        idle_inputs();
        cycle("abort_idle");

        // Timeout after 16 wait cycles; sticky until reset.
        MemReqM = 1'b1;
        for (int i = 0; i < 20; i++) cycle("to_wait");
        check("to_set", {31'd0, MemTimeout}, 32'd1);
        MemReadyM = 1'b1;
        cycle("to_ready");
        idle_inputs();
        cycle("to_idle");
        check("to_sticky", {31'd0, MemTimeout}, 32'd1);
        do_reset("to_rst");
        check("to_clear", {31'd0, MemTimeout}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            Rs1E      = 5'($urandom_range(0, 7));
            Rs2E      = 5'($urandom_range(0, 7));
            RdE       = 5'($urandom_range(0, 7));
            RdM       = 5'($urandom_range(0, 7));
            RdW       = 5'($urandom_range(0, 7));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReadE  = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            MemReqM   = ($urandom_range(0, 2) == 0);
            MemReadyM = ($urandom_range(0, 4) < 3);
            cycle("rnd");
            if (i == 200) begin
                idle_inputs();
                do_reset("rnd_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
